// File: rtl/rs_encode_stream_out_ctrl_if.sv
// Handshake, parity-memory and datapath strobe/status bundle between
// rs_encode_stream_out_ctrl (master) and its surrounding datapath (slave).
interface rs_encode_stream_out_ctrl_if #(
  parameter int NUM_REQ_BLOCKS   = 64,
  parameter int NUM_REQ_BLOCKS_W = $clog2(NUM_REQ_BLOCKS)
);
  logic                      in_datap_out_ctrl_meta_val;
  logic                      out_ctrl_in_datap_meta_rdy;
  logic [NUM_REQ_BLOCKS_W:0] in_datap_out_ctrl_req_num_blocks;
  logic                      line_encode_stream_out_ctrl_val;
  logic                      out_ctrl_line_encode_stream_rdy;
  logic                      stream_encoder_dst_resp_val;
  logic                      dst_stream_encoder_resp_rdy;
  logic                      stream_encoder_dst_resp_last;
  logic                      parity_mem_rd_req_val;
  logic                      parity_mem_wr_val;
  logic                      out_ctrl_out_datap_store_meta;
  logic                      out_ctrl_out_datap_init_req_state;
  logic                      out_ctrl_out_datap_incr_block_count;
  logic                      out_ctrl_out_datap_init_line_count;
  logic                      out_ctrl_out_datap_incr_line_count;
  logic                      out_ctrl_out_datap_incr_parity_wr_addr;
  logic                      out_ctrl_out_datap_incr_parity_rd_addr;
  logic                      out_ctrl_out_datap_parity_out;
  logic                      out_datap_out_ctrl_last_block;
  logic                      out_datap_out_ctrl_last_data_line;
  logic                      out_datap_out_ctrl_last_parity_line;

  modport master (
    input  in_datap_out_ctrl_meta_val, in_datap_out_ctrl_req_num_blocks,
           line_encode_stream_out_ctrl_val, dst_stream_encoder_resp_rdy,
           out_datap_out_ctrl_last_block, out_datap_out_ctrl_last_data_line,
           out_datap_out_ctrl_last_parity_line,
    output out_ctrl_in_datap_meta_rdy, out_ctrl_line_encode_stream_rdy,
           stream_encoder_dst_resp_val, stream_encoder_dst_resp_last,
           parity_mem_rd_req_val, parity_mem_wr_val,
           out_ctrl_out_datap_store_meta, out_ctrl_out_datap_init_req_state,
           out_ctrl_out_datap_incr_block_count, out_ctrl_out_datap_init_line_count,
           out_ctrl_out_datap_incr_line_count, out_ctrl_out_datap_incr_parity_wr_addr,
           out_ctrl_out_datap_incr_parity_rd_addr, out_ctrl_out_datap_parity_out
  );

  modport slave (
    output in_datap_out_ctrl_meta_val, in_datap_out_ctrl_req_num_blocks,
           line_encode_stream_out_ctrl_val, dst_stream_encoder_resp_rdy,
           out_datap_out_ctrl_last_block, out_datap_out_ctrl_last_data_line,
           out_datap_out_ctrl_last_parity_line,
    input  out_ctrl_in_datap_meta_rdy, out_ctrl_line_encode_stream_rdy,
           stream_encoder_dst_resp_val, stream_encoder_dst_resp_last,
           parity_mem_rd_req_val, parity_mem_wr_val,
           out_ctrl_out_datap_store_meta, out_ctrl_out_datap_init_req_state,
           out_ctrl_out_datap_incr_block_count, out_ctrl_out_datap_init_line_count,
           out_ctrl_out_datap_incr_line_count, out_ctrl_out_datap_incr_parity_wr_addr,
           out_ctrl_out_datap_incr_parity_rd_addr, out_ctrl_out_datap_parity_out
  );
endinterface

// File: rtl/rs_encode_stream_out_ctrl.sv
// Output-side control FSM for the RS encode stream: passes data lines to dst,
// writes each block's parity line to parity memory, then streams parity back out.
module rs_encode_stream_out_ctrl #(
  parameter int NUM_REQ_BLOCKS   = 64,
  parameter int NUM_REQ_BLOCKS_W = $clog2(NUM_REQ_BLOCKS)
) (
  input  logic                             clk,
  input  logic                             rst,
  rs_encode_stream_out_ctrl_if.master      bus
);

  typedef enum logic [2:0] {IDLE, DATA, PWR, PRD, POUT} state_e;

  state_e                    state_q, state_d;
  logic [NUM_REQ_BLOCKS_W:0] num_blocks;
  logic                      meta_fire, enc_fire, dst_fire;

  logic meta_rdy, enc_rdy, dst_val, dst_last, rd_req_val, wr_val;
  logic store_meta, init_req_state, incr_block_count, init_line_count;
  logic incr_line_count, incr_parity_wr_addr, incr_parity_rd_addr, parity_out;

  assign num_blocks = bus.in_datap_out_ctrl_req_num_blocks;
  assign meta_fire  = bus.in_datap_out_ctrl_meta_val & meta_rdy;
  assign enc_fire   = bus.line_encode_stream_out_ctrl_val & enc_rdy;
  assign dst_fire   = dst_val & bus.dst_stream_encoder_resp_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (meta_fire && (num_blocks != '0)) state_d = DATA;
      DATA: if (dst_fire && bus.out_datap_out_ctrl_last_data_line) state_d = PWR;
      PWR:  if (enc_fire) state_d = bus.out_datap_out_ctrl_last_block ? PRD : DATA;
      PRD:  state_d = POUT;
      POUT: if (dst_fire) state_d = bus.out_datap_out_ctrl_last_parity_line ? IDLE : PRD;
      default: state_d = IDLE;
    endcase
  end

  // IDLE outputs are gated by rst so every output reads 0 while reset is held.
  always_comb begin
    meta_rdy            = 1'b0;
    enc_rdy             = 1'b0;
    dst_val             = 1'b0;
    dst_last            = 1'b0;
    rd_req_val          = 1'b0;
    wr_val              = 1'b0;
    store_meta          = 1'b0;
    init_req_state      = 1'b0;
    incr_block_count    = 1'b0;
    init_line_count     = 1'b0;
    incr_line_count     = 1'b0;
    incr_parity_wr_addr = 1'b0;
    incr_parity_rd_addr = 1'b0;
    parity_out          = 1'b0;
    unique case (state_q)
      IDLE: begin
        meta_rdy = rst;
        if (bus.in_datap_out_ctrl_meta_val && rst) begin
          store_meta      = 1'b1;
          init_req_state  = 1'b1;
          init_line_count = 1'b1;
        end
      end
      DATA: begin
        dst_val = bus.line_encode_stream_out_ctrl_val;
        enc_rdy = bus.dst_stream_encoder_resp_rdy;
        if (bus.line_encode_stream_out_ctrl_val && bus.dst_stream_encoder_resp_rdy) begin
          if (bus.out_datap_out_ctrl_last_data_line) init_line_count = 1'b1;
          else                                       incr_line_count = 1'b1;
        end
      end
      PWR: begin
        enc_rdy = 1'b1;
        if (bus.line_encode_stream_out_ctrl_val) begin
          wr_val              = 1'b1;
          incr_parity_wr_addr = 1'b1;
          incr_block_count    = ~bus.out_datap_out_ctrl_last_block;
        end
      end
      PRD: begin
        rd_req_val          = 1'b1;
        incr_parity_rd_addr = 1'b1;
      end
      POUT: begin
        // Read address has already advanced, so last_parity_line flags this beat.
        parity_out = 1'b1;
        dst_val    = 1'b1;
        dst_last   = bus.out_datap_out_ctrl_last_parity_line;
      end
      default: ;
    endcase
  end

  assign bus.out_ctrl_in_datap_meta_rdy             = meta_rdy;
  assign bus.out_ctrl_line_encode_stream_rdy        = enc_rdy;
  assign bus.stream_encoder_dst_resp_val            = dst_val;
  assign bus.stream_encoder_dst_resp_last           = dst_last;
  assign bus.parity_mem_rd_req_val                  = rd_req_val;
  assign bus.parity_mem_wr_val                      = wr_val;
  assign bus.out_ctrl_out_datap_store_meta          = store_meta;
  assign bus.out_ctrl_out_datap_init_req_state      = init_req_state;
  assign bus.out_ctrl_out_datap_incr_block_count    = incr_block_count;
  assign bus.out_ctrl_out_datap_init_line_count     = init_line_count;
  assign bus.out_ctrl_out_datap_incr_line_count     = incr_line_count;
  assign bus.out_ctrl_out_datap_incr_parity_wr_addr = incr_parity_wr_addr;
  assign bus.out_ctrl_out_datap_incr_parity_rd_addr = incr_parity_rd_addr;
  assign bus.out_ctrl_out_datap_parity_out          = parity_out;

endmodule

// File: tb/tb_rs_encode_stream_out_ctrl.sv
// Bench for rs_encode_stream_out_ctrl: emulates meta queue, encoder, datap counters
// and parity memory, and scores dst beats / parity writes against per-request expectations.
module tb_rs_encode_stream_out_ctrl;
  localparam int NB = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rs_encode_stream_out_ctrl_if #(.NUM_REQ_BLOCKS(NB)) bus ();
  rs_encode_stream_out_ctrl #(.NUM_REQ_BLOCKS(NB)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  int n_tests = 0, n_fail = 0;
  int mq[$];
  int enc_q[$];
  logic [31:0] exp_beat[$];
  logic exp_last[$];
  logic [31:0] exp_wr[$];
  int tok = 1;
  int dp_num = 0, dp_blk = 0, dp_line = 0, dp_wr = 0, dp_rd = 0, mem_out = 0;
  bit rdy_rand = 0, enc_rand = 0, enc_hold = 0;
  bit prev_stall = 0, prev_rd = 0, arm = 0;
  logic [31:0] prev_beat = 0;
  int cyc = 0, last_cyc = 0, beats_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [13:0] outvec();
    return {bus.out_ctrl_in_datap_meta_rdy, bus.out_ctrl_line_encode_stream_rdy,
            bus.stream_encoder_dst_resp_val, bus.stream_encoder_dst_resp_last,
            bus.parity_mem_rd_req_val, bus.parity_mem_wr_val,
            bus.out_ctrl_out_datap_store_meta, bus.out_ctrl_out_datap_init_req_state,
            bus.out_ctrl_out_datap_incr_block_count, bus.out_ctrl_out_datap_init_line_count,
            bus.out_ctrl_out_datap_incr_line_count, bus.out_ctrl_out_datap_incr_parity_wr_addr,
            bus.out_ctrl_out_datap_incr_parity_rd_addr, bus.out_ctrl_out_datap_parity_out};
  endfunction

  // Reference: n blocks of 4 data lines + 1 parity line each from the encoder;
  // dst sees all data lines in order, then n/4 packed parity lines, last on the final one.
  task automatic expand(input int n);
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < 4; i++) begin
        enc_q.push_back(tok);
        exp_beat.push_back(32'(tok));
        exp_last.push_back(1'b0);
        tok++;
      end
      enc_q.push_back(tok);
      exp_wr.push_back(32'((b << 16) | tok));
      tok++;
    end
    for (int k = 0; k < n / 4; k++) begin
      exp_beat.push_back(32'h10000 | 32'(k));
      exp_last.push_back(k == n / 4 - 1);
    end
  endtask

  task automatic drive_meta();
    bus.in_datap_out_ctrl_meta_val       = (mq.size() != 0);
    bus.in_datap_out_ctrl_req_num_blocks = (mq.size() != 0) ? 7'(mq[0]) : 7'd0;
  endtask

  task automatic drive();
    drive_meta();
    bus.line_encode_stream_out_ctrl_val = (enc_q.size() != 0) &&
                                          (enc_hold || !enc_rand || ($urandom_range(0, 1) == 1));
    bus.dst_stream_encoder_resp_rdy     = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    bus.out_datap_out_ctrl_last_data_line   = (dp_line == 3);
    bus.out_datap_out_ctrl_last_block       = (dp_blk == dp_num - 1);
    bus.out_datap_out_ctrl_last_parity_line = (dp_rd == dp_num / 4);
  endtask

  task automatic push_req(input int n);
    mq.push_back(n);
    drive_meta();
  endtask

  task automatic cycle();
    logic mf, ef, df, lst;
    logic s_store, s_ireq, s_iline, s_incl, s_iblk, s_iwr, s_ird, s_rd;
    logic [31:0] beat;
    int s_num;
    @(negedge clk);
    mf = bus.in_datap_out_ctrl_meta_val & bus.out_ctrl_in_datap_meta_rdy;
    ef = bus.line_encode_stream_out_ctrl_val & bus.out_ctrl_line_encode_stream_rdy;
    df = bus.stream_encoder_dst_resp_val & bus.dst_stream_encoder_resp_rdy;
    beat = bus.out_ctrl_out_datap_parity_out ? (32'h10000 | 32'(mem_out))
         : ((enc_q.size() != 0) ? 32'(enc_q[0]) : 32'hdead);

    chk("meta_rdy_excl", 32'(bus.out_ctrl_in_datap_meta_rdy &
        (bus.out_ctrl_line_encode_stream_rdy | bus.stream_encoder_dst_resp_val |
         bus.parity_mem_rd_req_val | bus.out_ctrl_out_datap_parity_out)), 0);
    if (prev_rd) chk("prd_then_pout", 32'(bus.out_ctrl_out_datap_parity_out), 1);
    if (prev_stall) begin
      chk("hold_val", 32'(bus.stream_encoder_dst_resp_val), 1);
      chk("hold_dat", beat, prev_beat);
    end
    if (mf) begin
      chk("meta_strobes", 32'({bus.out_ctrl_out_datap_store_meta, bus.out_ctrl_out_datap_init_req_state,
                               bus.out_ctrl_out_datap_init_line_count}), 32'd7);
      if (arm) chk("b2b_gap", 32'(cyc - last_cyc), 1);
      arm = 0;
    end
    if (df) begin
      beats_seen++;
      if (exp_beat.size() == 0) chk("extra_beat", 32'(beat), 32'hffffffff);
      else begin
        chk("beat", beat, exp_beat.pop_front());
        lst = exp_last.pop_front();
        chk("resp_last", 32'(bus.stream_encoder_dst_resp_last), 32'(lst));
        if (lst) begin
          arm = (mq.size() != 0);
          last_cyc = cyc;
        end
      end
    end
    if (bus.parity_mem_wr_val) begin
      if (exp_wr.size() == 0) chk("extra_wr", 32'(dp_wr), 32'hffffffff);
      else chk("parity_wr", 32'((dp_wr << 16) | ((enc_q.size() != 0) ? enc_q[0] : 0)), exp_wr.pop_front());
    end
    prev_stall = bus.stream_encoder_dst_resp_val & ~bus.dst_stream_encoder_resp_rdy;
    prev_beat  = beat;
    prev_rd    = bus.parity_mem_rd_req_val;
    enc_hold   = bus.line_encode_stream_out_ctrl_val & ~ef;
    s_store = bus.out_ctrl_out_datap_store_meta;
    s_ireq  = bus.out_ctrl_out_datap_init_req_state;
    s_iline = bus.out_ctrl_out_datap_init_line_count;
    s_incl  = bus.out_ctrl_out_datap_incr_line_count;
    s_iblk  = bus.out_ctrl_out_datap_incr_block_count;
    s_iwr   = bus.out_ctrl_out_datap_incr_parity_wr_addr;
    s_ird   = bus.out_ctrl_out_datap_incr_parity_rd_addr;
    s_rd    = bus.parity_mem_rd_req_val;
    s_num   = int'(bus.in_datap_out_ctrl_req_num_blocks);

    @(posedge clk);
    #1;
    if (mf && mq.size() != 0) expand(mq.pop_front());
    if (ef && enc_q.size() != 0) void'(enc_q.pop_front());
    if (s_store) dp_num = s_num;
    if (s_ireq) begin dp_blk = 0; dp_wr = 0; dp_rd = 0; end
    if (s_iline) dp_line = 0;
    else if (s_incl) dp_line++;
    if (s_iblk) dp_blk++;
    if (s_iwr) dp_wr++;
    if (s_rd) mem_out = dp_rd;
    if (s_ird) dp_rd++;
    cyc++;
    drive();
  endtask

  task automatic run(input int budget);
    int c = 0;
    while ((mq.size() + enc_q.size() + exp_beat.size() + exp_wr.size()) != 0 && c < budget) begin
      cycle();
      c++;
    end
    chk("timeout", 32'(c >= budget), 0);
    @(negedge clk);
    chk("idle_meta_rdy", 32'(bus.out_ctrl_in_datap_meta_rdy), 1);
    @(posedge clk);
    #1;
    cyc++;
    prev_stall = 0;
    prev_rd = 0;
  endtask

  task automatic flush();
    mq.delete(); enc_q.delete(); exp_beat.delete(); exp_last.delete(); exp_wr.delete();
    arm = 0; prev_stall = 0; prev_rd = 0; enc_hold = 0;
  endtask

  initial begin
    int c;
    // Inputs active during reset: outputs must still read 0.
    bus.in_datap_out_ctrl_meta_val          = 1'b1;
    bus.in_datap_out_ctrl_req_num_blocks    = 7'd4;
    bus.line_encode_stream_out_ctrl_val     = 1'b1;
    bus.dst_stream_encoder_resp_rdy         = 1'b1;
    bus.out_datap_out_ctrl_last_block       = 1'b1;
    bus.out_datap_out_ctrl_last_data_line   = 1'b1;
    bus.out_datap_out_ctrl_last_parity_line = 1'b1;
    #12;
    chk("reset_outputs", 32'(outvec()), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive();

    push_req(4);  run(400);                         // single 4-block request
    push_req(8);  run(600);                         // two parity lines
    rdy_rand = 1;
    push_req(8);  run(1500);                        // dst stalls
    rdy_rand = 0;
    push_req(0);  push_req(4); run(600);            // empty request then normal
    push_req(4);  push_req(4); run(800);            // back-to-back

    // Reset in the middle of an 8-block request's data phase.
    push_req(8);
    beats_seen = 0;
    c = 0;
    while (beats_seen < 10 && c < 300) begin cycle(); c++; end
    chk("mid_req_reached", 32'(beats_seen >= 10), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_reset_outputs", 32'(outvec()), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    flush();
    rst = 1'b1;
    drive();
    push_req(4);  run(400);

    // Randomised mix of sizes, dst stalls and encoder gaps.
    rdy_rand = 1;
    enc_rand = 1;
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < 3; j++) push_req(4 * int'($urandom_range(0, 4)));
      run(4000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
